hxmpp_readout: RTL and testbench

Read-side sequencer for the HXMPP hit store: accepts one SSID request at a time and queries the HNM read port to check whether the SSID holds hits. If it does, it reads the HCM read port for the hit count and base HIM address, then streams each hit-info word from the HIM read port on a valid/ready output. It is the consumer of the HNM → HCM → HIM write chain and sits between the downstream track-fitting requester and the three memories' read ports.

---
 rtl/hxmpp_readout.sv | 232 +++++++++++++++++++++++
 tb/tb_hxmpp_readout.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hxmpp_readout.sv
// HXMPP read-side sequencer: HNM lookup, HCM count/base fetch, then HIM hit-info streaming.
// Optional feature macro: HXMPP_READOUT_EMPTY_RECORD_EN (emit an empty-marker record on a miss).
module hxmpp_readout #(
  parameter int unsigned SSIDBITS         = 16,
  parameter int unsigned ROWINDEXBITS_HIM = 10,
  parameter int unsigned HITINFOBITS      = 32,
  parameter int unsigned MAXHITNBITS      = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        req_valid,
  input  logic [SSIDBITS-1:0]         req_ssid,
  output logic                        req_ready,
  output logic                        hnm_rd_en,
  output logic [SSIDBITS-1:0]         hnm_rd_ssid,
  input  logic                        hnm_rd_valid,
  input  logic                        hnm_rd_hit,
  output logic                        hcm_rd_en,
  output logic [SSIDBITS-1:0]         hcm_rd_ssid,
  input  logic                        hcm_rd_valid,
  input  logic [MAXHITNBITS-1:0]      hcm_rd_nhits,
  input  logic [ROWINDEXBITS_HIM-1:0] hcm_rd_addr,
  output logic                        him_rd_en,
  output logic [ROWINDEXBITS_HIM-1:0] him_rd_addr,
  input  logic                        him_rd_valid,
  input  logic [HITINFOBITS-1:0]      him_rd_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [SSIDBITS-1:0]         out_ssid,
  output logic [HITINFOBITS-1:0]      out_hitinfo,
  output logic                        out_last,
  output logic                        out_empty,
  output logic                        done,
  output logic                        err
);

  typedef enum logic [2:0] {
    StIdle,
    StHnmWait,
    StHcmWait,
    StHimWait,
    StEmit
  } state_e;

  state_e                      state_q, state_d;
  logic [SSIDBITS-1:0]         ssid_q, ssid_d;
  logic [ROWINDEXBITS_HIM-1:0] addr_q, addr_d;
  logic [MAXHITNBITS-1:0]      remaining_q, remaining_d;
  logic                        req_ready_q, req_ready_d;
  logic                        hnm_rd_en_q, hnm_rd_en_d;
  logic                        hcm_rd_en_q, hcm_rd_en_d;
  logic                        him_rd_en_q, him_rd_en_d;
  logic                        out_valid_q, out_valid_d;
  logic                        out_last_q, out_last_d;
  logic [HITINFOBITS-1:0]      out_hitinfo_q, out_hitinfo_d;
  logic                        done_q, done_d;
  logic                        err_q, err_d;
  logic                        empty_cmpl;
`ifdef HXMPP_READOUT_EMPTY_RECORD_EN
  logic                        out_empty_q, out_empty_d;
`endif

  // Every output is registered so that reset drives all of them low, req_ready included.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      ssid_q        <= '0;
      addr_q        <= '0;
      remaining_q   <= '0;
      req_ready_q   <= 1'b0;
      hnm_rd_en_q   <= 1'b0;
      hcm_rd_en_q   <= 1'b0;
      him_rd_en_q   <= 1'b0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      out_hitinfo_q <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
`ifdef HXMPP_READOUT_EMPTY_RECORD_EN
      out_empty_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      ssid_q        <= ssid_d;
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      req_ready_q   <= req_ready_d;
      hnm_rd_en_q   <= hnm_rd_en_d;
      hcm_rd_en_q   <= hcm_rd_en_d;
      him_rd_en_q   <= him_rd_en_d;
      out_valid_q   <= out_valid_d;
      out_last_q    <= out_last_d;
      out_hitinfo_q <= out_hitinfo_d;
      done_q        <= done_d;
      err_q         <= err_d;
`ifdef HXMPP_READOUT_EMPTY_RECORD_EN
      out_empty_q   <= out_empty_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    ssid_d        = ssid_q;
    addr_d        = addr_q;
    remaining_d   = remaining_q;
    req_ready_d   = 1'b0;
    hnm_rd_en_d   = 1'b0;
    hcm_rd_en_d   = 1'b0;
    him_rd_en_d   = 1'b0;
    out_valid_d   = out_valid_q;
    out_last_d    = out_last_q;
    out_hitinfo_d = out_hitinfo_q;
    done_d        = 1'b0;
    empty_cmpl    = 1'b0;
`ifdef HXMPP_READOUT_EMPTY_RECORD_EN
    out_empty_d   = out_empty_q;
`endif

    // A response strobe is only legal while its own read is outstanding.
    err_d = err_q
          | (hnm_rd_valid && (state_q != StHnmWait))
          | (hcm_rd_valid && (state_q != StHcmWait))
          | (him_rd_valid && (state_q != StHimWait));

    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready_q) begin
          ssid_d      = req_ssid;
          hnm_rd_en_d = 1'b1;
          state_d     = StHnmWait;
        end else begin
          req_ready_d = 1'b1;
        end
      end

      StHnmWait: begin
        if (hnm_rd_valid) begin
          if (hnm_rd_hit) begin
            hcm_rd_en_d = 1'b1;
            state_d     = StHcmWait;
          end else begin
            empty_cmpl = 1'b1;
          end
        end
      end

      StHcmWait: begin
        if (hcm_rd_valid) begin
          remaining_d = hcm_rd_nhits;
          addr_d      = hcm_rd_addr;
          if (hcm_rd_nhits == '0) begin
            empty_cmpl = 1'b1;
          end else begin
            him_rd_en_d = 1'b1;
            state_d     = StHimWait;
          end
        end
      end

      StHimWait: begin
        if (him_rd_valid) begin
          out_valid_d   = 1'b1;
          out_hitinfo_d = him_rd_data;
          out_last_d    = (remaining_q == MAXHITNBITS'(1));
`ifdef HXMPP_READOUT_EMPTY_RECORD_EN
          out_empty_d   = 1'b0;
`endif
          state_d       = StEmit;
        end
      end

      StEmit: begin
        if (out_ready) begin
          out_valid_d   = 1'b0;
          out_last_d    = 1'b0;
          out_hitinfo_d = '0;
`ifdef HXMPP_READOUT_EMPTY_RECORD_EN
          out_empty_d   = 1'b0;
`endif
          if (out_last_q) begin
            done_d      = 1'b1;
            req_ready_d = 1'b1;
            state_d     = StIdle;
          end else begin
            // Address wraps naturally at the HIM depth.
            remaining_d = remaining_q - MAXHITNBITS'(1);
            addr_d      = addr_q + ROWINDEXBITS_HIM'(1);
            him_rd_en_d = 1'b1;
            state_d     = StHimWait;
          end
        end
      end

      default: state_d = StIdle;
    endcase

    if (empty_cmpl) begin
`ifdef HXMPP_READOUT_EMPTY_RECORD_EN
      out_valid_d   = 1'b1;
      out_last_d    = 1'b1;
      out_empty_d   = 1'b1;
      out_hitinfo_d = '0;
      state_d       = StEmit;
`else
      done_d        = 1'b1;
      req_ready_d   = 1'b1;
      state_d       = StIdle;
`endif
    end
  end

  assign req_ready   = req_ready_q;
  assign hnm_rd_en   = hnm_rd_en_q;
  assign hnm_rd_ssid = ssid_q;
  assign hcm_rd_en   = hcm_rd_en_q;
  assign hcm_rd_ssid = ssid_q;
  assign him_rd_en   = him_rd_en_q;
  assign him_rd_addr = addr_q;
  assign out_valid   = out_valid_q;
  assign out_ssid    = ssid_q;
  assign out_hitinfo = out_hitinfo_q;
  assign out_last    = out_last_q;
  assign done        = done_q;
  assign err         = err_q;
`ifdef HXMPP_READOUT_EMPTY_RECORD_EN
  assign out_empty   = out_empty_q;
`else
  assign out_empty   = 1'b0;
`endif

endmodule

// File: tb/tb_hxmpp_readout.sv
// Bench for hxmpp_readout: memory responders with random latency, expected-record model per request.
module tb_hxmpp_readout;

`ifdef HXMPP_READOUT_EMPTY_RECORD_EN
  localparam bit EmptyEn = 1'b1;
`else
  localparam bit EmptyEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [15:0] req_ssid;
  logic        req_ready;
  logic        hnm_rd_en;
  logic [15:0] hnm_rd_ssid;
  logic        hnm_rd_valid;
  logic        hnm_rd_hit;
  logic        hcm_rd_en;
  logic [15:0] hcm_rd_ssid;
  logic        hcm_rd_valid;
  logic [3:0]  hcm_rd_nhits;
  logic [9:0]  hcm_rd_addr;
  logic        him_rd_en;
  logic [9:0]  him_rd_addr;
  logic        him_rd_valid;
  logic [31:0] him_rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_ssid;
  logic [31:0] out_hitinfo;
  logic        out_last;
  logic        out_empty;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  hxmpp_readout dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ssid     (req_ssid),
    .req_ready    (req_ready),
    .hnm_rd_en    (hnm_rd_en),
    .hnm_rd_ssid  (hnm_rd_ssid),
    .hnm_rd_valid (hnm_rd_valid),
    .hnm_rd_hit   (hnm_rd_hit),
    .hcm_rd_en    (hcm_rd_en),
    .hcm_rd_ssid  (hcm_rd_ssid),
    .hcm_rd_valid (hcm_rd_valid),
    .hcm_rd_nhits (hcm_rd_nhits),
    .hcm_rd_addr  (hcm_rd_addr),
    .him_rd_en    (him_rd_en),
    .him_rd_addr  (him_rd_addr),
    .him_rd_valid (him_rd_valid),
    .him_rd_data  (him_rd_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_ssid     (out_ssid),
    .out_hitinfo  (out_hitinfo),
    .out_last     (out_last),
    .out_empty    (out_empty),
    .done         (done),
    .err          (err)
  );

  typedef struct packed {
    logic [15:0] ssid;
    logic [31:0] info;
    logic        is_last;
    logic        is_empty;
  } rec_t;

  rec_t        exp_q[$];
  logic [9:0]  exp_addr_q[$];
  logic [31:0] obs_info[$];
  logic        obs_last[$];
  logic        obs_empty[$];
  logic [9:0]  obs_addr[$];
  int          obs_cyc[$];

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  int          hcm_cnt = 0;
  int          cyc = 0;
  logic [31:0] him_mem [1024];
  bit          cur_hit;
  logic [3:0]  cur_nhits;
  logic [9:0]  cur_addr;
  int          lat_max = 0;
  int          ready_mode = 0;
  bit          inject_hcm = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, expv);
    end
  endtask

  task automatic clear_obs();
    obs_info.delete();
    obs_last.delete();
    obs_empty.delete();
    obs_addr.delete();
    obs_cyc.delete();
  endtask

  // Memory responders: answer each strobe after 1..1+lat_max cycles, with one-cycle valid.
  initial begin : responder
    int         hnm_dly;
    int         hcm_dly;
    int         him_dly;
    logic [9:0] him_a;
    hnm_dly = 0; hcm_dly = 0; him_dly = 0; him_a = '0;
    hnm_rd_valid = 1'b0; hnm_rd_hit = 1'b0;
    hcm_rd_valid = 1'b0; hcm_rd_nhits = '0; hcm_rd_addr = '0;
    him_rd_valid = 1'b0; him_rd_data = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (hnm_rd_en) hnm_dly = 1 + int'($urandom_range(lat_max));
        if (hcm_rd_en) hcm_dly = 1 + int'($urandom_range(lat_max));
        if (him_rd_en) begin
          him_dly = 1 + int'($urandom_range(lat_max));
          him_a   = him_rd_addr;
        end
      end
      @(posedge clk);
      #1;
      hnm_rd_valid = 1'b0;
      hcm_rd_valid = 1'b0;
      him_rd_valid = 1'b0;
      if (!reset) begin
        hnm_dly = 0; hcm_dly = 0; him_dly = 0;
      end
      if (hnm_dly > 0) begin
        hnm_dly--;
        if (hnm_dly == 0) begin hnm_rd_valid = 1'b1; hnm_rd_hit = cur_hit; end
      end
      if (hcm_dly > 0) begin
        hcm_dly--;
        if (hcm_dly == 0) begin
          hcm_rd_valid = 1'b1; hcm_rd_nhits = cur_nhits; hcm_rd_addr = cur_addr;
        end
      end
      if (him_dly > 0) begin
        him_dly--;
        if (him_dly == 0) begin him_rd_valid = 1'b1; him_rd_data = him_mem[him_a]; end
      end
      if (inject_hcm) begin
        hcm_rd_valid = 1'b1; hcm_rd_nhits = 4'd5; hcm_rd_addr = 10'h123;
        inject_hcm = 1'b0;
      end
    end
  end

  // 0: always ready, 1: random ready, other: held low.
  initial begin : ready_drv
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(9) < 7);
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial begin : compare
    bit          pv;
    bit          pr;
    bit          plast_hs;
    logic [49:0] pfields;
    logic [49:0] cur;
    rec_t        r;
    pv = 1'b0; pr = 1'b0; plast_hs = 1'b0; pfields = '0;
    forever begin
      @(negedge clk);
      cyc++;
      cur = {out_ssid, out_hitinfo, out_last, out_empty};
      if (!reset) begin
        pv = 1'b0; plast_hs = 1'b0;
      end else begin
        if (plast_hs) begin
          chk("done_after_last", done, 1'b1);
          chk("ready_after_last", req_ready, 1'b1);
        end
        if (pv && !pr) begin
          chk("stall_valid_held", out_valid, 1'b1);
          chk("stall_fields_held", cur, pfields);
          chk("stall_no_him_en", him_rd_en, 1'b0);
        end
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_record: got 0x%0h, required no record", cur);
          end else begin
            chk("record", cur, exp_q[0]);
            if (out_ready) begin
              r = exp_q.pop_front();
              obs_info.push_back(out_hitinfo);
              obs_last.push_back(out_last);
              obs_empty.push_back(out_empty);
              obs_cyc.push_back(cyc);
            end
          end
        end
        if (him_rd_en) begin
          if (exp_addr_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_him_read: got addr 0x%0h, required no read", him_rd_addr);
          end else begin
            chk("him_addr", him_rd_addr, exp_addr_q.pop_front());
          end
          obs_addr.push_back(him_rd_addr);
        end
        if (hcm_rd_en) hcm_cnt++;
        if (done) done_cnt++;
        pv       = out_valid;
        pr       = out_ready;
        plast_hs = out_valid && out_ready && out_last;
        pfields  = cur;
      end
    end
  end

  task automatic do_req(input logic [15:0] s, input bit h, input int n, input logic [9:0] a);
    int         guard;
    int         d0;
    logic [9:0] ai;
    rec_t       r;
    cur_hit   = h;
    cur_nhits = 4'(n);
    cur_addr  = a;
    if (h && n > 0) begin
      for (int i = 0; i < n; i++) begin
        ai = 10'((int'(a) + i) % 1024);
        r.ssid = s; r.info = him_mem[ai]; r.is_last = (i == n - 1); r.is_empty = 1'b0;
        exp_q.push_back(r);
        exp_addr_q.push_back(ai);
      end
    end else if (EmptyEn) begin
      r.ssid = s; r.info = '0; r.is_last = 1'b1; r.is_empty = 1'b1;
      exp_q.push_back(r);
    end
    guard = 0;
    while (!req_ready && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    d0 = done_cnt;
    req_ssid  = s;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("hnm_strobe", hnm_rd_en, 1'b1);
    chk("hnm_ssid", hnm_rd_ssid, s);
    chk("ready_low_busy", req_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("hnm_strobe_one_cycle", hnm_rd_en, 1'b0);
    guard = 0;
    while (done_cnt == d0 && guard < 500) begin
      @(posedge clk);
      #1;
      guard++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("done_once", done_cnt - d0, 1);
    chk("records_drained", exp_q.size(), 0);
    chk("him_reads_drained", exp_addr_q.size(), 0);
  endtask

  initial begin : main
    int          g;
    int          d0;
    int          h0;
    int          n;
    logic [15:0] s;
    logic [9:0]  a;
    bit          h;
    req_valid = 1'b0;
    req_ssid  = '0;
    reset     = 1'b0;
    for (int i = 0; i < 1024; i++) him_mem[i] = $urandom;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {req_ready, hnm_rd_en, hcm_rd_en, him_rd_en, out_valid, out_last,
                       out_empty, done, err}, 0);
    chk("reset_bus", {hnm_rd_ssid, hcm_rd_ssid, him_rd_addr, out_ssid, out_hitinfo}, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("ready_before_edge", req_ready, 1'b0);
    @(posedge clk);
    #1;
    chk("ready_first_edge", req_ready, 1'b1);

    // Basic three-hit readout with single-cycle memories.
    lat_max = 0; ready_mode = 0;
    him_mem[10'h040] = 32'hA; him_mem[10'h041] = 32'hB; him_mem[10'h042] = 32'hC;
    clear_obs();
    h0 = hcm_cnt;
    do_req(16'h0012, 1'b1, 3, 10'h040);
    chk("t1_nrec", obs_info.size(), 3);
    chk("t1_data", {obs_info[0], obs_info[1], obs_info[2]}, {32'hA, 32'hB, 32'hC});
    chk("t1_last", {obs_last[0], obs_last[1], obs_last[2]}, 3'b001);
    chk("t1_addr", {obs_addr[0], obs_addr[1], obs_addr[2]}, {10'h040, 10'h041, 10'h042});
    chk("t1_rate", obs_cyc[1] - obs_cyc[0], 3);
    chk("t1_hcm_once", hcm_cnt - h0, 1);

    // Miss on HNM.
    clear_obs();
    h0 = hcm_cnt;
    do_req(16'h0007, 1'b0, 0, 10'h000);
    chk("t2_nrec", obs_info.size(), EmptyEn ? 1 : 0);
    for (int i = 0; i < obs_info.size(); i++)
      chk("t2_empty_rec", {obs_empty[i], obs_last[i], obs_info[i]}, {1'b1, 1'b1, 32'h0});
    chk("t2_no_hcm", hcm_cnt - h0, 0);

    // Address wrap.
    lat_max = 1;
    clear_obs();
    do_req(16'h0123, 1'b1, 2, 10'h3FF);
    chk("t3_addr", {obs_addr[0], obs_addr[1]}, {10'h3FF, 10'h000});

    // Consumer stall for five cycles.
    ready_mode = 2;
    fork
      do_req(16'h0033, 1'b1, 2, 10'h100);
      begin
        g = 0;
        while (!out_valid && g < 200) begin
          @(negedge clk);
          g++;
        end
        chk("t4_stall_reached", out_valid, 1'b1);
        repeat (5) begin
          @(negedge clk);
          chk("t4_stall_no_him", him_rd_en, 1'b0);
          chk("t4_stall_valid", out_valid, 1'b1);
        end
        ready_mode = 0;
      end
    join

    // Randomized traffic.
    ready_mode = 1;
    for (int k = 0; k < 40; k++) begin
      lat_max = int'($urandom_range(2));
      h = ($urandom_range(9) < 7);
      n = int'($urandom_range(6));
      a = ($urandom_range(3) == 0) ? 10'(10'h3FC + $urandom_range(3)) : 10'($urandom);
      s = 16'($urandom);
      do_req(s, h, n, a);
    end
    chk("err_clean", err, 1'b0);

    // Reset while a HIM read is outstanding.
    lat_max = 2; ready_mode = 0;
    cur_hit = 1'b1; cur_nhits = 4'd3; cur_addr = 10'h200;
    exp_addr_q.push_back(10'h200);
    g = 0;
    while (!req_ready && g < 100) begin
      @(posedge clk);
      #1;
      g++;
    end
    req_ssid = 16'h0055; req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    g = 0;
    while (!him_rd_en && g < 100) begin
      @(negedge clk);
      g++;
    end
    chk("t5_in_him_wait", him_rd_en, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    chk("t5_rst_ctrl", {req_ready, hnm_rd_en, hcm_rd_en, him_rd_en, out_valid, out_last,
                        out_empty, done, err}, 0);
    chk("t5_rst_bus", {hnm_rd_ssid, hcm_rd_ssid, him_rd_addr, out_ssid, out_hitinfo}, 0);
    exp_q.delete();
    exp_addr_q.delete();
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_ready_back", req_ready, 1'b1);
    clear_obs();
    do_req(16'h0066, 1'b1, 2, 10'h010);
    chk("t5_after_nrec", obs_info.size(), 2);

    // Stray HCM response while idle.
    chk("t6_err_clear", err, 1'b0);
    d0 = done_cnt;
    inject_hcm = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_err_set", err, 1'b1);
    chk("t6_idle_ready", req_ready, 1'b1);
    chk("t6_no_done", done_cnt - d0, 0);
    chk("t6_no_record", out_valid, 1'b0);
    do_req(16'h0077, 1'b1, 1, 10'h3A0);
    chk("t6_err_sticky", err, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #500000;
    errors++;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
